// File: rtl/lives_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : lives_pkg
//  Brief    : Shared types and helpers for the lives / respawn controller.
//  Revision : 1.0 - initial release
// ============================================================================
package lives_pkg;

    localparam int LIVES_W = 2;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ALIVE    = 3'd1,
        ST_DYING    = 3'd2,
        ST_INVULN   = 3'd3,
        ST_GAMEOVER = 3'd4
    } ctrl_state_t;

    // Counter must be able to hold the longest of the two sequence lengths.
    function automatic int frame_cnt_width(input int death_frames, input int invuln_frames);
        int longest;
        longest = (death_frames > invuln_frames) ? death_frames : invuln_frames;
        return $clog2(longest + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/lives_controller_frame_timer.sv
`default_nettype none
// ============================================================================
//  Module   : frame_timer
//  Brief    : Counts frame ticks up to a terminal value and pulses done on the
//             terminal tick; synchronous clear and hold (pause).
//  Revision : 1.0 - initial release
// ============================================================================
module frame_timer #(
    parameter int CNT_W = 7
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic             clear,
    input  logic             hold,
    input  logic             tick,
    input  logic [CNT_W-1:0] terminal,
    output logic             done
);

    logic [CNT_W-1:0] r_count;
    logic             w_last;
    logic             w_adv;

    assign w_last = (r_count == terminal - CNT_W'(1));
    assign w_adv  = tick & ~hold;
    // Combinational so the controller reacts on the very edge that sees the last tick.
    assign done   = w_adv & w_last;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (w_adv) begin
            r_count <= w_last ? '0 : r_count + CNT_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/lives_controller.sv
`default_nettype none
// ============================================================================
//  Module   : lives_controller
//  Brief    : Life count and death / respawn sequencing; drives the lives icon
//             bitmap and the ship datapath. Optional extra lives are compiled
//             in with LIVES_CTRL_EXTRA_LIFE_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module lives_controller
    import lives_pkg::*;
#(
    parameter int INIT_LIVES        = 3,
    parameter int MAX_LIVES         = 3,
    parameter int DEATH_FRAMES      = 60,
    parameter int INVULN_FRAMES     = 120,
    parameter int BLINK_HALF_FRAMES = 8
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               startOfFrame,
    input  logic               newGame,
    input  logic               playerHit,
    input  logic               extraLife,
    input  logic               pause,
    output logic [LIVES_W-1:0] livesDisplay,
    output logic [LIVES_W-1:0] lives,
    output logic               playerEnable,
    output logic               invulnerable,
    output logic               shipBlinkOn,
    output logic               gameOver,
    output logic               lifeLostPulse
);

    localparam int CNT_W = frame_cnt_width(DEATH_FRAMES, INVULN_FRAMES);

    localparam logic [CNT_W-1:0]   c_death  = CNT_W'(DEATH_FRAMES);
    localparam logic [CNT_W-1:0]   c_invuln = CNT_W'(INVULN_FRAMES);
    localparam logic [CNT_W-1:0]   c_blink  = CNT_W'(BLINK_HALF_FRAMES);
    localparam logic [LIVES_W-1:0] c_init   = LIVES_W'(INIT_LIVES);
    localparam logic [LIVES_W-1:0] c_max    = LIVES_W'(MAX_LIVES);
    localparam logic [LIVES_W-1:0] c_full   = '1;

    ctrl_state_t        r_state;
    ctrl_state_t        w_state_nxt;
    logic               r_phase;
    logic               w_phase_nxt;
    logic [LIVES_W-1:0] w_lives_nxt;
    logic [LIVES_W-1:0] w_lives_inc;
    logic               w_lost_nxt;
    logic               w_hit;
    logic               w_xl;
    logic               w_counting;
    logic               w_timer_clear;
    logic               w_phase_done;
    logic               w_blink_done;
    logic [CNT_W-1:0]   w_phase_term;

    logic [LIVES_W-1:0] w_disp_nxt;
    logic               w_enable_nxt;
    logic               w_invuln_nxt;
    logic               w_blink_nxt;
    logic               w_over_nxt;

`ifdef LIVES_CTRL_EXTRA_LIFE_EN
    assign w_xl = extraLife;
`else
    logic w_unused_extra;
    assign w_xl           = 1'b0;
    assign w_unused_extra = extraLife;
`endif

    assign w_hit        = playerHit & ~pause;
    assign w_lives_inc  = (lives >= c_max) ? c_max : lives + LIVES_W'(1);
    assign w_counting   = (r_state == ST_DYING) || (r_state == ST_INVULN);
    assign w_phase_term = (r_state == ST_INVULN) ? c_invuln : c_death;
    // Both timers restart on every state change so each sequence starts from frame 0.
    assign w_timer_clear = newGame | ~w_counting | (w_state_nxt != r_state);

    frame_timer #(.CNT_W(CNT_W)) u_phase_timer (
        .clk      (clk),
        .resetN   (resetN),
        .clear    (w_timer_clear),
        .hold     (pause),
        .tick     (startOfFrame),
        .terminal (w_phase_term),
        .done     (w_phase_done)
    );

    frame_timer #(.CNT_W(CNT_W)) u_blink_timer (
        .clk      (clk),
        .resetN   (resetN),
        .clear    (w_timer_clear),
        .hold     (pause),
        .tick     (startOfFrame),
        .terminal (c_blink),
        .done     (w_blink_done)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_lives_nxt = lives;
        w_lost_nxt  = 1'b0;
        if (newGame) begin
            w_state_nxt = ST_ALIVE;
            w_lives_nxt = c_init;
        end else begin
            case (r_state)
                ST_ALIVE: begin
                    if (w_hit) begin
                        w_lost_nxt = 1'b1;
                        if (w_xl) begin
                            w_state_nxt = ST_DYING;
                        end else if (lives == LIVES_W'(1)) begin
                            w_state_nxt = ST_GAMEOVER;
                            w_lives_nxt = '0;
                        end else begin
                            w_state_nxt = ST_DYING;
                            w_lives_nxt = lives - LIVES_W'(1);
                        end
                    end else if (w_xl) begin
                        w_lives_nxt = w_lives_inc;
                    end
                end
                ST_DYING: begin
                    if (w_xl) w_lives_nxt = w_lives_inc;
                    if (w_phase_done) w_state_nxt = ST_INVULN;
                end
                ST_INVULN: begin
                    if (w_xl) w_lives_nxt = w_lives_inc;
                    if (w_phase_done) w_state_nxt = ST_ALIVE;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_phase_nxt = r_phase;
        if (w_timer_clear) begin
            w_phase_nxt = 1'b0;
        end else if (w_blink_done) begin
            w_phase_nxt = ~r_phase;
        end
    end

    // Output decode from next-state values so every output comes straight off a flop.
    always_comb begin
        w_disp_nxt   = w_lives_nxt;
        w_enable_nxt = 1'b0;
        w_invuln_nxt = 1'b0;
        w_blink_nxt  = 1'b1;
        w_over_nxt   = 1'b0;
        case (w_state_nxt)
            ST_ALIVE: begin
                w_enable_nxt = 1'b1;
            end
            ST_DYING: begin
                if (!w_phase_nxt) begin
                    w_disp_nxt = (w_lives_nxt == c_full) ? c_full : w_lives_nxt + LIVES_W'(1);
                end
            end
            ST_INVULN: begin
                w_enable_nxt = 1'b1;
                w_invuln_nxt = 1'b1;
                w_blink_nxt  = w_phase_nxt;
            end
            ST_GAMEOVER: begin
                w_over_nxt = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state       <= ST_IDLE;
            r_phase       <= 1'b0;
            lives         <= c_init;
            livesDisplay  <= c_init;
            playerEnable  <= 1'b0;
            invulnerable  <= 1'b0;
            shipBlinkOn   <= 1'b1;
            gameOver      <= 1'b0;
            lifeLostPulse <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_phase       <= w_phase_nxt;
            lives         <= w_lives_nxt;
            livesDisplay  <= w_disp_nxt;
            playerEnable  <= w_enable_nxt;
            invulnerable  <= w_invuln_nxt;
            shipBlinkOn   <= w_blink_nxt;
            gameOver      <= w_over_nxt;
            lifeLostPulse <= w_lost_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lives_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lives_controller
//  Brief    : Self-checking bench for lives_controller against a frame-level
//             behavioural model; directed scenarios followed by random traffic.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_lives_controller;

    localparam int INIT   = 3;
    localparam int MAXL   = 3;
    localparam int DEATH  = 60;
    localparam int INV    = 120;
    localparam int BHALF  = 8;
`ifdef LIVES_CTRL_EXTRA_LIFE_EN
    localparam bit XL = 1'b1;
`else
    localparam bit XL = 1'b0;
`endif

    // model modes
    localparam int M_IDLE = 0, M_ALIVE = 1, M_DYING = 2, M_INVULN = 3, M_OVER = 4;

    logic       clk = 1'b0;
    logic       resetN = 1'b0;
    logic       startOfFrame = 1'b0;
    logic       newGame = 1'b0;
    logic       playerHit = 1'b0;
    logic       extraLife = 1'b0;
    logic       pause = 1'b0;
    logic [1:0] livesDisplay;
    logic [1:0] lives;
    logic       playerEnable;
    logic       invulnerable;
    logic       shipBlinkOn;
    logic       gameOver;
    logic       lifeLostPulse;

    int n_cmp = 0;
    int n_bad = 0;
    int frame_ctr = 0;

    int m_mode  = M_IDLE;
    int m_lives = INIT;
    int m_k     = 0;
    int m_lost  = 0;

    always #5 clk = ~clk;

    lives_controller #(
        .INIT_LIVES        (INIT),
        .MAX_LIVES         (MAXL),
        .DEATH_FRAMES      (DEATH),
        .INVULN_FRAMES     (INV),
        .BLINK_HALF_FRAMES (BHALF)
    ) dut (
        .clk           (clk),
        .resetN        (resetN),
        .startOfFrame  (startOfFrame),
        .newGame       (newGame),
        .playerHit     (playerHit),
        .extraLife     (extraLife),
        .pause         (pause),
        .livesDisplay  (livesDisplay),
        .lives         (lives),
        .playerEnable  (playerEnable),
        .invulnerable  (invulnerable),
        .shipBlinkOn   (shipBlinkOn),
        .gameOver      (gameOver),
        .lifeLostPulse (lifeLostPulse)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model (frame-count level) ----------------
    function automatic int sat_add(input int v);
        return (v + 1 > MAXL) ? MAXL : v + 1;
    endfunction

    task automatic model_step();
        m_lost = 0;
        if (newGame) begin
            m_mode = M_ALIVE; m_lives = INIT; m_k = 0;
        end else begin
            case (m_mode)
                M_ALIVE: begin
                    if (playerHit && !pause) begin
                        m_lost = 1;
                        m_k = 0;
                        if (!(XL && extraLife)) m_lives = m_lives - 1;
                        m_mode = (m_lives == 0) ? M_OVER : M_DYING;
                    end else if (XL && extraLife) begin
                        m_lives = sat_add(m_lives);
                    end
                end
                M_DYING, M_INVULN: begin
                    if (XL && extraLife) m_lives = sat_add(m_lives);
                    if (startOfFrame && !pause) begin
                        m_k++;
                        if (m_mode == M_DYING && m_k == DEATH) begin
                            m_mode = M_INVULN; m_k = 0;
                        end else if (m_mode == M_INVULN && m_k == INV) begin
                            m_mode = M_ALIVE; m_k = 0;
                        end
                    end
                end
                default: ;
            endcase
        end
    endtask

    function automatic int exp_disp();
        int up;
        up = (m_lives + 1 > 3) ? 3 : m_lives + 1;
        if (m_mode == M_DYING && ((m_k / BHALF) % 2 == 0)) return up;
        return m_lives;
    endfunction

    // One compare process: model advances on each edge, DUT checked 1 time unit later.
    always @(posedge clk) begin
        if (!resetN) begin
            m_mode = M_IDLE; m_lives = INIT; m_k = 0; m_lost = 0;
        end else begin
            model_step();
        end
        #1;
        chk("livesDisplay",  livesDisplay,  exp_disp());
        chk("lives",         lives,         m_lives);
        chk("playerEnable",  playerEnable,  int'(m_mode == M_ALIVE || m_mode == M_INVULN));
        chk("invulnerable",  invulnerable,  int'(m_mode == M_INVULN));
        chk("shipBlinkOn",   shipBlinkOn,   (m_mode == M_INVULN) ? int'((m_k / BHALF) % 2 == 1) : 1);
        chk("gameOver",      gameOver,      int'(m_mode == M_OVER));
        chk("lifeLostPulse", lifeLostPulse, m_lost);
    end

    // ---------------- stimulus ----------------
    task automatic step(input bit ng, input bit hit, input bit xl);
        @(negedge clk);
        startOfFrame = (frame_ctr % 4 == 0);
        frame_ctr++;
        newGame   = ng;
        playerHit = hit;
        extraLife = xl;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic wait_alive();
        int ok;
        ok = 0;
        for (int i = 0; i < 3000; i++) begin
            if (playerEnable && !invulnerable) begin ok = 1; break; end
            step(1'b0, 1'b0, 1'b0);
        end
        chk("wait_alive", ok, 1);
    endtask

    task automatic wait_invuln();
        int ok;
        ok = 0;
        for (int i = 0; i < 3000; i++) begin
            if (invulnerable) begin ok = 1; break; end
            step(1'b0, 1'b0, 1'b0);
        end
        chk("wait_invuln", ok, 1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_disp"},  livesDisplay, 3);
        chk({tag, "_lives"}, lives, 3);
        chk({tag, "_en"},    playerEnable, 0);
        chk({tag, "_inv"},   invulnerable, 0);
        chk({tag, "_blink"}, shipBlinkOn, 1);
        chk({tag, "_over"},  gameOver, 0);
        chk({tag, "_lost"},  lifeLostPulse, 0);
    endtask

    initial begin
        int run;
        int held;
        int ok;

        idle(3);
        chk_reset_vals("reset");
        resetN = 1'b1;
        idle(2);

        // New game and first hit
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk("ng_lives", lives, 3);
        chk("ng_enable", playerEnable, 1);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk("hit_pulse", lifeLostPulse, 1);
        chk("hit_lives", lives, 2);
        chk("hit_disp", livesDisplay, 3);
        chk("hit_enable", playerEnable, 0);
        chk("model_lives_after_hit", m_lives, 2);
        step(1'b0, 1'b0, 1'b0);
        chk("hit_pulse_once", lifeLostPulse, 0);

        // Hit while dying is ignored; display blinks down after 8 frames
        idle(36);
        chk("dying_disp_8f", livesDisplay, 2);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk("dying_hit_ignored", lives, 2);
        wait_invuln();
        chk("invuln_blink_start", shipBlinkOn, 0);
        chk("invuln_disp", livesDisplay, 2);

        // Pause 20 frames inside invulnerability; exactly 120 live frames still needed
        run = 0; held = 0; ok = 0;
        for (int i = 0; i < 4000; i++) begin
            if (!invulnerable) begin ok = 1; break; end
            pause = (run >= 30 && held < 20);
            step(1'b0, (held == 5), 1'b0);
            if (startOfFrame) begin
                if (pause) held++;
                else run++;
            end
        end
        pause = 1'b0;
        chk("invuln_exit", ok, 1);
        chk("invuln_live_frames", run, INV);
        chk("alive_again_inv", invulnerable, 0);
        chk("alive_again_blink", shipBlinkOn, 1);
        chk("alive_again_en", playerEnable, 1);

        // Hit while paused is ignored
        pause = 1'b1;
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk("paused_hit_lives", lives, 2);
        chk("paused_hit_pulse", lifeLostPulse, 0);
        pause = 1'b0;

        // Down to game over
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk("second_hit_lives", lives, 1);
        wait_alive();
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk("go_flag", gameOver, 1);
        chk("go_lives", lives, 0);
        chk("go_disp", livesDisplay, 0);
        chk("go_pulse", lifeLostPulse, 1);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk("go_hit_ignored", lives, 0);
        chk("go_hit_nopulse", lifeLostPulse, 0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk("restart_lives", lives, 3);
        chk("restart_over", gameOver, 0);

        // newGame wins over a coincident hit
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk("ng_hit_lives", lives, 3);
        chk("ng_hit_pulse", lifeLostPulse, 0);
        chk("ng_hit_enable", playerEnable, 1);

`ifdef LIVES_CTRL_EXTRA_LIFE_EN
        step(1'b0, 1'b1, 1'b0);
        wait_alive();
        chk("xl_base", lives, 2);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        chk("xl_saturate", lives, 3);
        step(1'b0, 1'b1, 1'b0);
        wait_alive();
        step(1'b0, 1'b1, 1'b0);
        wait_alive();
        chk("xl_one_left", lives, 1);
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        chk("xl_hit_lives", lives, 1);
        chk("xl_hit_pulse", lifeLostPulse, 1);
        chk("xl_hit_dying", playerEnable, 0);
        chk("xl_hit_not_over", gameOver, 0);
`endif

        // Reset in the middle of a death sequence
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        idle(30);
        resetN = 1'b0;
        idle(3);
        chk_reset_vals("midreset");
        resetN = 1'b1;
        idle(5);
        chk_reset_vals("post_reset_idle");

        // Random traffic
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 8000; i++) begin
            if ($urandom_range(0, 79) == 0) pause = ~pause;
            step(($urandom_range(0, 299) == 0),
                 ($urandom_range(0, 39) == 0),
                 ($urandom_range(0, 59) == 0));
        end
        pause = 1'b0;
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, compared %0d mismatched %0d", n_cmp, n_bad);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/lives_controller.md
Name: lives_controller

Overview:
- Owns the player's life count and the death/respawn sequence for the game.
- Drives the lives icon bitmap with the number of icons to show, including blinking the icon just lost.
- Drives the ship datapath with enable, invulnerability and blink flags.
- Consumes per-frame timing, collision and game-control pulses from the game logic.

Parameters:
- INIT_LIVES, 3, lives loaded on new game (1..MAX_LIVES)
- MAX_LIVES, 3, saturation limit for extra lives (≤3, fits 2 bits)
- DEATH_FRAMES, 60, frames spent in death sequence
- INVULN_FRAMES, 120, frames of post-respawn invulnerability
- BLINK_HALF_FRAMES, 8, frames per blink half-period

Ports:
- clk  in  1  system clock
- resetN  in  1  async active-low reset
- startOfFrame  in  1  one-cycle pulse, once per video frame
- newGame  in  1  one-cycle pulse, (re)start game
- playerHit  in  1  one-cycle pulse, player collision
- extraLife  in  1  one-cycle pulse, score bonus reached
- pause  in  1  level; freezes timers and hit processing
- livesDisplay  out  2  icon count for the lives bitmap
- lives  out  2  true life count
- playerEnable  out  1  ship drawn and controllable
- invulnerable  out  1  collisions ignored by the game logic
- shipBlinkOn  out  1  ship visible phase (1 = visible)
- gameOver  out  1  level, game-over screen
- lifeLostPulse  out  1  one cycle on each accepted hit

Behaviour:
- Reset and clock: resetN asynchronous, active-low; clk is the clock. All outputs registered.
- Reset values: state IDLE, lives = INIT_LIVES, livesDisplay = INIT_LIVES, playerEnable 0, invulnerable 0, shipBlinkOn 1, gameOver 0, lifeLostPulse 0, frame and blink counters 0.
- States: IDLE, ALIVE, DYING, INVULN, GAMEOVER.
- newGame has highest priority in every state. Next cycle: ALIVE, lives = INIT_LIVES, counters cleared, gameOver 0.
- IDLE: outputs at reset values; waits for newGame.
- ALIVE: playerEnable 1, shipBlinkOn 1.
  - playerHit with pause = 0: lives decrements next cycle and lifeLostPulse asserts for one cycle.
  - If the new count is 0, go to GAMEOVER; otherwise go to DYING with counters cleared.
- DYING: playerEnable 0.
  - Counts startOfFrame pulses.
  - livesDisplay alternates between lives+1 and lives every BLINK_HALF_FRAMES frames, starting at lives+1.
  - On the DEATH_FRAMES-th pulse: go to INVULN, livesDisplay = lives.
- INVULN: playerEnable 1, invulnerable 1.
  - shipBlinkOn toggles every BLINK_HALF_FRAMES frames, starting at 0.
  - On the INVULN_FRAMES-th pulse: go to ALIVE, shipBlinkOn 1, invulnerable 0.
- GAMEOVER: gameOver 1, playerEnable 0, lives = livesDisplay = 0; only newGame exits.
- playerHit is ignored in IDLE, DYING, INVULN and GAMEOVER, and whenever pause = 1.
- pause = 1: frame and blink counters hold; state holds; newGame is still honoured.
- Outside DYING, livesDisplay = lives. Counter widths are $clog2(max(DEATH_FRAMES, INVULN_FRAMES)+1).
- Extra lives are handled only when LIVES_CTRL_EXTRA_LIFE_EN is defined (see Optional Feature).

Optional Feature:
- Macro: LIVES_CTRL_EXTRA_LIFE_EN.
- Defined:
  - extraLife in ALIVE, DYING or INVULN increments lives, saturating at MAX_LIVES.
  - extraLife is ignored in IDLE and GAMEOVER.
  - playerHit and extraLife in the same ALIVE cycle: lives unchanged, lifeLostPulse 1, next state DYING.
- Undefined: extraLife port present but ignored; lives never increase after load.

Decomposition:
- lives_pkg holds:
  - the state enum typedef (ctrl_state_t)
  - LIVES_W = 2
  - a function computing frame-counter width
- Sub-module frame_timer:
  - counts startOfFrame pulses to a terminal value, with sync clear and hold (pause) inputs
  - emits a one-cycle done pulse
  - instantiated twice: phase timer (death/invuln) and blink timer.

Test Plan:
- Reset mid-DYING: resetN low for 3 cycles → all outputs at reset values, state IDLE, no lifeLostPulse after release.
- Hit then timing (defaults): newGame, then playerHit →
  - lives 3→2 and one lifeLostPulse;
  - livesDisplay toggles 3/2 every 8 frames for 60 frames;
  - INVULN for 120 frames with shipBlinkOn toggling every 8 frames;
  - then ALIVE with invulnerable 0.
- Hits during DYING/INVULN and while paused are ignored. Pause held 20 frames in INVULN extends invulnerability by exactly 20 frames.
- Three accepted hits from 3 lives → after the third, gameOver 1 and lives 0. A further playerHit causes no change; newGame → ALIVE, lives 3, gameOver 0.
- With LIVES_CTRL_EXTRA_LIFE_EN defined:
  - lives 2, extraLife ×2 → lives 3 (saturated);
  - simultaneous playerHit+extraLife at lives 1 → lives 1, DYING.
- newGame asserted in the same cycle as playerHit in ALIVE → ALIVE, lives 3, no lifeLostPulse.
